// File: rtl/vmx_pkg.sv
// vmx_pkg: FSM state type and shared constants for the vmx array scheduler.
package vmx_pkg;
   typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_t;
   localparam int IW_BITS = 8;
   localparam int DEF_SIZE = 4;
   localparam int DEF_VECTOR_BITLEN = 16;
endpackage

// File: rtl/vmx_skew_line.sv
// vmx_skew_line: fixed-depth register delay line; DEPTH 0 degenerates to a wire.
module vmx_skew_line #(
   parameter int DEPTH = 1,
   parameter int WIDTH = 1
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   generate
      if (DEPTH == 0) begin : g_wire
         assign q = d;
      end else begin : g_dly
         logic [WIDTH-1:0] r [DEPTH];
         always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) for (int k = 0; k < DEPTH; k++) r[k] <= '0;
            else begin
               r[0] <= d;
               for (int k = 1; k < DEPTH; k++) r[k] <= r[k-1];
            end
         assign q = r[DEPTH-1];
      end
   endgenerate
endmodule

// File: rtl/vmx_array_sched.sv
// vmx_array_sched: command/beat scheduler feeding a SIZE x SIZE vector array.
// Define VMX_SCHED_SKEW_EN to skew columns internally and de-skew the product row.
module vmx_array_sched
   import vmx_pkg::*;
#(
   parameter int SIZE = DEF_SIZE,
   parameter int VECTOR_BITLEN = DEF_VECTOR_BITLEN,
   parameter int PRODUCT_BITLEN = 2*VECTOR_BITLEN
)(
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             cmd_valid,
   output logic                             cmd_ready,
   input  logic                             cmd_load_w,
   input  logic [SIZE-1:0]                  cmd_simd,
   input  logic [15:0]                      cmd_len,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [VECTOR_BITLEN*SIZE-1:0]    in_data,
   output logic [IW_BITS*SIZE-1:0]          arr_is_weight,
   output logic [SIZE-1:0]                  arr_simd_mode,
   output logic [VECTOR_BITLEN*SIZE-1:0]    arr_vector,
   input  logic [PRODUCT_BITLEN*SIZE-1:0]   arr_product,
   output logic                             out_valid,
   output logic [PRODUCT_BITLEN*SIZE-1:0]   out_data,
   output logic                             busy
);
`ifdef VMX_SCHED_SKEW_EN
   localparam int LAT = 3*SIZE-1;
`else
   localparam int LAT = 2*SIZE;
`endif
   state_t state, state_nxt;
   logic [15:0] cnt, len_q;
   logic [SIZE-1:0] simd_q;
   logic [LAT-1:0] vline;
   logic beat;
   logic [IW_BITS-1:0] wt;
   logic [IW_BITS*SIZE-1:0] iw;
   logic [VECTOR_BITLEN*SIZE-1:0] vec;
   logic [PRODUCT_BITLEN*SIZE-1:0] prod;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;

   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      in_ready  = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) state_nxt = cmd_load_w ? LOAD_W : STREAM;
         end
         LOAD_W: begin
            in_ready = 1'b1;
            if (in_valid && cnt == 16'(SIZE-1)) state_nxt = DRAIN;
         end
         STREAM: begin
            in_ready = 1'b1;
            if (in_valid && cnt == len_q - 16'd1) state_nxt = DRAIN;
         end
         DRAIN: if (cnt == 16'(2*SIZE-1)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign beat = in_valid & in_ready;
   assign busy = state != IDLE;
   // Load beat k tags every lane with the row it targets: SIZE-k.
   assign wt  = (beat && state == LOAD_W) ? IW_BITS'(SIZE - int'(cnt)) : '0;
   assign iw  = {SIZE{wt}};
   assign vec = beat ? in_data : '0;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt       <= '0;
         len_q     <= '0;
         simd_q    <= '0;
         vline     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         cnt <= (state != state_nxt) ? '0 : (beat || state == DRAIN) ? cnt + 16'd1 : cnt;
         if (cmd_valid && cmd_ready) begin
            simd_q <= cmd_simd;
            len_q  <= (cmd_len == 16'd0) ? 16'd1 : cmd_len;
         end
         vline     <= {vline[LAT-2:0], beat && state == STREAM};
         out_valid <= vline[LAT-1];
         if (vline[LAT-1]) out_data <= prod;
      end

`ifdef VMX_SCHED_SKEW_EN
   for (genvar j = 0; j < SIZE; j++) begin : g_skew
      vmx_skew_line #(.DEPTH(j), .WIDTH(VECTOR_BITLEN+IW_BITS+1)) u_col (
         .clk(clk), .rst_n(rst_n),
         .d({vec[j*VECTOR_BITLEN +: VECTOR_BITLEN], iw[j*IW_BITS +: IW_BITS], simd_q[j]}),
         .q({arr_vector[j*VECTOR_BITLEN +: VECTOR_BITLEN], arr_is_weight[j*IW_BITS +: IW_BITS], arr_simd_mode[j]})
      );
      vmx_skew_line #(.DEPTH(SIZE-1-j), .WIDTH(PRODUCT_BITLEN)) u_row (
         .clk(clk), .rst_n(rst_n),
         .d(arr_product[j*PRODUCT_BITLEN +: PRODUCT_BITLEN]),
         .q(prod[j*PRODUCT_BITLEN +: PRODUCT_BITLEN])
      );
   end
`else
   assign arr_vector    = vec;
   assign arr_is_weight = iw;
   assign arr_simd_mode = simd_q;
   assign prod          = arr_product;
`endif
endmodule

// File: tb/tb_vmx_array_sched.sv
// tb_vmx_array_sched: randomized job-level bench for vmx_array_sched (default, unskewed build).
module tb_vmx_array_sched;
   localparam int SIZE = 4, VB = 16, PB = 32, LAT = 2*SIZE;
   logic clk = 1'b0, rst_n = 1'b1;
   logic cmd_valid = 1'b0, cmd_ready, cmd_load_w = 1'b0;
   logic [SIZE-1:0] cmd_simd = '0;
   logic [15:0] cmd_len = '0;
   logic in_valid = 1'b0, in_ready;
   logic [VB*SIZE-1:0] in_data = '0, arr_vector;
   logic [8*SIZE-1:0] arr_is_weight;
   logic [SIZE-1:0] arr_simd_mode;
   logic [PB*SIZE-1:0] arr_product = '0, out_data;
   logic out_valid, busy;
   int checks = 0, failures = 0, cyc = 0;
   bit exp_v [int];
   logic [PB*SIZE-1:0] prod_hist [int];
   bit mon_on = 1'b0;

   vmx_array_sched #(.SIZE(SIZE), .VECTOR_BITLEN(VB), .PRODUCT_BITLEN(PB)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_load_w(cmd_load_w), .cmd_simd(cmd_simd), .cmd_len(cmd_len),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .arr_is_weight(arr_is_weight), .arr_simd_mode(arr_simd_mode), .arr_vector(arr_vector),
      .arr_product(arr_product), .out_valid(out_valid), .out_data(out_data), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) begin
      #1;
      arr_product = {$urandom, $urandom, $urandom, $urandom};
   end

   // Scoreboard: a stream beat accepted at edge n must produce one pulse at edge n+LAT
   // carrying the array row presented just before that edge.
   always @(negedge clk) if (mon_on) begin
      prod_hist[cyc] = arr_product;
      checks++;
      if (out_valid !== exp_v.exists(cyc)) begin
         failures++;
         $display("FAIL out_valid cyc=%0d got=%0b exp=%0b", cyc, out_valid, exp_v.exists(cyc));
      end
      if (exp_v.exists(cyc)) begin
         checks++;
         if (out_data !== prod_hist[cyc-1]) begin
            failures++;
            $display("FAIL out_data cyc=%0d got=%h exp=%h", cyc, out_data, prod_hist[cyc-1]);
         end
         exp_v.delete(cyc);
      end
   end

   task automatic run_job(input bit load, input logic [SIZE-1:0] simd, input logic [15:0] len, input int gap);
      int nb, g;
      logic [VB*SIZE-1:0] d;
      logic [8*SIZE-1:0] w;
      nb = load ? SIZE : (len == 16'd0 ? 1 : int'(len));
      cmd_valid = 1'b1; cmd_load_w = load; cmd_simd = simd; cmd_len = len;
      @(negedge clk);
      checks++;
      if ({cmd_ready, in_ready, busy} !== 3'b100) begin
         failures++;
         $display("FAIL idle_ctrl got=%b exp=100", {cmd_ready, in_ready, busy});
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      for (int k = 0; k < nb; k++) begin
         g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
         for (int i = 0; i <= g; i++) begin
            in_valid = (i == g);
            in_data = {$urandom, $urandom};
            d = in_valid ? in_data : '0;
            w = (in_valid && load) ? {SIZE{8'(SIZE - k)}} : '0;
            @(negedge clk);
            checks++;
            if ({cmd_ready, in_ready, busy, arr_simd_mode} !== {3'b011, simd}) begin
               failures++;
               $display("FAIL job_ctrl beat=%0d got=%b exp=%b", k, {cmd_ready, in_ready, busy, arr_simd_mode}, {3'b011, simd});
            end
            checks++;
            if ({arr_vector, arr_is_weight} !== {d, w}) begin
               failures++;
               $display("FAIL job_lanes beat=%0d got=%h/%h exp=%h/%h", k, arr_vector, arr_is_weight, d, w);
            end
            @(posedge clk); #1;
         end
         if (!load) exp_v[cyc + LAT] = 1'b1;
      end
      in_valid = 1'b0;
      for (int k = 0; k < 2*SIZE; k++) begin
         @(negedge clk);
         checks++;
         if ({cmd_ready, in_ready, busy, arr_simd_mode, arr_vector, arr_is_weight} !== {3'b001, simd, {(VB*SIZE+8*SIZE){1'b0}}}) begin
            failures++;
            $display("FAIL drain k=%0d got=%b%b%b simd=%b vec=%h iw=%h", k, cmd_ready, in_ready, busy, arr_simd_mode, arr_vector, arr_is_weight);
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      checks++;
      if ({cmd_ready, in_ready, busy} !== 3'b100) begin
         failures++;
         $display("FAIL back_to_idle got=%b exp=100", {cmd_ready, in_ready, busy});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({cmd_ready, in_ready, busy, out_valid} !== 4'b1000) begin
         failures++;
         $display("FAIL reset_ctrl got=%b exp=1000", {cmd_ready, in_ready, busy, out_valid});
      end
      checks++;
      if ({arr_is_weight, arr_simd_mode, arr_vector, out_data} !== '0) begin
         failures++;
         $display("FAIL reset_data got=%h/%b/%h/%h exp=0", arr_is_weight, arr_simd_mode, arr_vector, out_data);
      end
      rst_n = 1'b1;
      mon_on = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_cmd_holdoff();
      int waited;
      cmd_valid = 1'b1; cmd_load_w = 1'b0; cmd_simd = 4'b1010; cmd_len = 16'd2;
      @(posedge clk); #1;
      cmd_load_w = 1'b1; cmd_simd = 4'b0101;
      in_valid = 1'b1;
      for (int k = 0; k < 2; k++) begin
         in_data = {$urandom, $urandom};
         @(negedge clk);
         checks++;
         if ({cmd_ready, in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL holdoff_stream got=%b exp=01", {cmd_ready, in_ready});
         end
         @(posedge clk); #1;
         exp_v[cyc + LAT] = 1'b1;
      end
      in_valid = 1'b0;
      waited = 0;
      while (waited < 100) begin
         @(negedge clk);
         if (cmd_ready) break;
         waited++;
         @(posedge clk); #1;
      end
      checks++;
      if (waited !== 2*SIZE) begin
         failures++;
         $display("FAIL holdoff_wait got=%0d exp=%0d", waited, 2*SIZE);
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      in_valid = 1'b1;
      for (int k = 0; k < SIZE; k++) begin
         in_data = {$urandom, $urandom};
         @(negedge clk);
         checks++;
         if ({in_ready, busy, arr_simd_mode, arr_is_weight} !== {2'b11, 4'b0101, {SIZE{8'(SIZE - k)}}}) begin
            failures++;
            $display("FAIL holdoff_load k=%0d got=%b/%b/%h", k, {in_ready, busy}, arr_simd_mode, arr_is_weight);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      repeat (2*SIZE) @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL holdoff_idle got=%b exp=0", busy);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_job();
      cmd_valid = 1'b1; cmd_load_w = 1'b0; cmd_simd = 4'b1111; cmd_len = 16'd5;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      in_valid = 1'b1;
      for (int k = 0; k < 2; k++) begin
         in_data = {$urandom, $urandom};
         @(posedge clk); #1;
         exp_v[cyc + LAT] = 1'b1;
      end
      rst_n = 1'b0;
      #1;
      exp_v.delete();
      checks++;
      if ({cmd_ready, in_ready, busy, out_valid} !== 4'b1000) begin
         failures++;
         $display("FAIL midrst_ctrl got=%b exp=1000", {cmd_ready, in_ready, busy, out_valid});
      end
      checks++;
      if ({arr_is_weight, arr_simd_mode, arr_vector, out_data} !== '0) begin
         failures++;
         $display("FAIL midrst_data got=%h/%b/%h/%h exp=0", arr_is_weight, arr_simd_mode, arr_vector, out_data);
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3*SIZE) @(posedge clk);
      #1;
   endtask

   initial begin
      test_reset();
      run_job(1'b1, 4'b0000, 16'd0, 0);
      run_job(1'b0, 4'($urandom), 16'd3, 0);
      run_job(1'b0, 4'($urandom), 16'd2, 2);
      test_cmd_holdoff();
      run_job(1'b0, 4'($urandom), 16'd0, 0);
      repeat (6) run_job(1'($urandom_range(0, 1)), 4'($urandom), 16'($urandom_range(1, 6)), -1);
      test_reset_mid_job();
      run_job(1'b0, 4'b0011, 16'd1, 0);
      repeat (3*SIZE) @(posedge clk);
      @(negedge clk);
      checks++;
      if (exp_v.size() !== 0) begin
         failures++;
         $display("FAIL pulses_missing got=%0d exp=0", exp_v.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
